ex_div_ctrl: RTL and testbench

Multi-cycle divide sequencer for the EX stage of the RV64 pipeline. It accepts an RV64M divide or remainder request (DIV/DIVU/REM/REMU and the W forms), runs a radix-2 restoring division over 64 or 32 iterations, and stalls the pipeline through `stall_o` until the result is ready. It presents the result for exactly one cycle, which the EX stage muxes over the ALU result. A flush from the branch unit or a trap abandons the operation.

---
 rtl/ex_div_ctrl_pkg.sv | 21 ++
 rtl/ex_div_ctrl_step.sv | 20 ++
 rtl/ex_div_ctrl.sv | 121 ++++++++++++
 tb/tb_ex_div_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ex_div_ctrl_pkg.sv
// Shared constants and types for the EX-stage divide sequencer.
package ex_div_ctrl_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] DIV_DIV  = 3'b100;
    localparam logic [2:0] DIV_DIVU = 3'b101;
    localparam logic [2:0] DIV_REM  = 3'b110;
    localparam logic [2:0] DIV_REMU = 3'b111;

    typedef enum logic [1:0] {
        DIVST_IDLE = 2'd0,
        DIVST_CALC = 2'd1,
        DIVST_DONE = 2'd2
    } div_state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/ex_div_ctrl_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract.
module div_step
    import ex_div_ctrl_pkg::*;
(
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] dvs_i,
    input  logic            bit_i,
    output logic [XLEN:0]   rem_o,
    output logic            q_o
);

    logic [XLEN+1:0] shl;
    logic [XLEN+1:0] diff;

    assign shl   = {rem_i, bit_i};
    assign diff  = shl - {2'b00, dvs_i};
    assign q_o   = ~diff[XLEN+1];
    assign rem_o = q_o ? diff[XLEN:0] : shl[XLEN:0];

endmodule

// File: rtl/ex_div_ctrl.sv
// RV64M divide/remainder sequencer: radix-2 restoring, stalls EX until done.
module ex_div_ctrl
    import ex_div_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            div_valid_i,
    input  logic [2:0]      div_sel_i,
    input  logic            is_word_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            div_done_o,
    output logic [XLEN-1:0] div_res_o
);

    div_state_e      state_q, state_d;
    logic [5:0]      cnt_q;
    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] quo_q, dvs_q, spec_res_q;
    logic            spec_q, word_q, rem_op_q, neg_q_q, neg_r_q;

    logic            req, accept, op_signed, op_rem;
    logic [XLEN-1:0] a_w, b_w, a_mag, b_mag, a_res;
    logic            a_neg, b_neg, div_zero, ovf, spec;
    logic [XLEN-1:0] spec_res;

    logic [XLEN:0]   step_rem;
    logic            step_q;
    logic [XLEN-1:0] q_val, r_val, raw, calc, fin;

    assign req       = div_valid_i & div_sel_i[2];
    assign accept    = (state_q == DIVST_IDLE) & req & ~flush_i;
    assign op_signed = (div_sel_i == DIV_DIV) | (div_sel_i == DIV_REM);
    assign op_rem    = ~((div_sel_i == DIV_DIV) | (div_sel_i == DIV_DIVU));

    // Working operands at the active width, then magnitudes
    assign a_w = is_word_i ? (op_signed ? sext32(src1_i[31:0])
                                        : {32'b0, src1_i[31:0]}) : src1_i;
    assign b_w = is_word_i ? (op_signed ? sext32(src2_i[31:0])
                                        : {32'b0, src2_i[31:0]}) : src2_i;
    assign a_neg = op_signed & a_w[XLEN-1];
    assign b_neg = op_signed & b_w[XLEN-1];
    assign a_mag = a_neg ? -a_w : a_w;
    assign b_mag = b_neg ? -b_w : b_w;
    assign a_res = is_word_i ? sext32(src1_i[31:0]) : src1_i;

    assign div_zero = is_word_i ? (src2_i[31:0] == 32'd0) : (src2_i == '0);
    assign ovf = op_signed & (is_word_i
        ? ((src1_i[31:0] == 32'h8000_0000) & (&src2_i[31:0]))
        : ((src1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&src2_i)));
    assign spec = div_zero | ovf;
    assign spec_res = div_zero ? (op_rem ? a_res : '1)
                               : (op_rem ? '0 : a_res);

    div_step u_step (
        .rem_i (rem_q),
        .dvs_i (dvs_q),
        .bit_i (quo_q[XLEN-1]),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    assign q_val = neg_q_q ? -quo_q : quo_q;
    assign r_val = neg_r_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    assign raw   = rem_op_q ? r_val : q_val;
    assign calc  = word_q ? sext32(raw[31:0]) : raw;
    assign fin   = spec_q ? spec_res_q : calc;

    assign div_done_o = (state_q == DIVST_DONE) & ~flush_i;
    assign div_res_o  = div_done_o ? fin : '0;
    assign stall_o    = req & ~div_done_o & ~flush_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIVST_IDLE: if (accept) state_d = spec ? DIVST_DONE : DIVST_CALC;
            DIVST_CALC: if (cnt_q == 6'd0) state_d = DIVST_DONE;
            DIVST_DONE: state_d = DIVST_IDLE;
            default:    state_d = DIVST_IDLE;
        endcase
        if (flush_i) state_d = DIVST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIVST_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            spec_res_q <= '0;
            spec_q     <= 1'b0;
            word_q     <= 1'b0;
            rem_op_q   <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q      <= is_word_i ? 6'd31 : 6'd63;
                rem_q      <= '0;
                // Word dividends are left-aligned so bit 31 is shifted first
                quo_q      <= is_word_i ? {a_mag[31:0], 32'b0} : a_mag;
                dvs_q      <= b_mag;
                spec_res_q <= spec_res;
                spec_q     <= spec;
                word_q     <= is_word_i;
                rem_op_q   <= op_rem;
                neg_q_q    <= a_neg ^ b_neg;
                neg_r_q    <= a_neg;
            end else if ((state_q == DIVST_CALC) && !flush_i) begin
                rem_q <= step_rem;
                quo_q <= {quo_q[XLEN-2:0], step_q};
                if (cnt_q != 6'd0) cnt_q <= cnt_q - 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed bench for ex_div_ctrl with an expected-result scoreboard.
module tb_ex_div_ctrl;
    import ex_div_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_valid_i;
    logic [2:0]  div_sel_i;
    logic        is_word_i;
    logic [63:0] src1_i;
    logic [63:0] src2_i;
    logic        flush_i;
    logic        stall_o;
    logic        div_done_o;
    logic [63:0] div_res_o;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];
    int          lat_q[$];

    ex_div_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .div_valid_i(div_valid_i),
        .div_sel_i  (div_sel_i),
        .is_word_i  (is_word_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .div_done_o (div_done_o),
        .div_res_o  (div_res_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sel, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
        rst         = 1'b0;
        flush_i     = 1'b0;
        div_valid_i = 1'b1;
        div_sel_i   = sel;
        is_word_i   = w;
        src1_i      = a;
        src2_i      = b;
    endtask

    // Issue one request in the next cycle and follow it to completion
    task automatic run_op(input string tag, input logic [2:0] sel,
                          input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp,
                          input int lat);
        int k;
        logic got;
        logic [63:0] e;
        int l;
        @(posedge clk); #1;
        exp_q.push_back(exp);
        lat_q.push_back(lat);
        drive(sel, w, a, b);
        #1 chk({tag, "_stall_acc"}, 64'(stall_o), 64'd1);
        k = 0;
        got = 1'b0;
        while (!got && k < 100) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) begin
                src1_i = {$urandom, $urandom};
                src2_i = {$urandom, $urandom};
            end
            if (div_done_o === 1'b1) got = 1'b1;
            else if (k == 1 || k == lat - 1)
                chk({tag, "_stall"}, {stall_o, div_res_o[62:0]}, 64'h8000_0000_0000_0000);
        end
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        chk({tag, "_done"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, "_lat"}, 64'(k), 64'(l));
            chk({tag, "_res"}, div_res_o, e);
            chk({tag, "_stall_done"}, 64'(stall_o), 64'd0);
        end
        div_valid_i = 1'b0;
    endtask

    initial begin
        logic [63:0] ra, rb;
        rst = 1'b1;
        flush_i = 1'b0;
        div_valid_i = 1'b0;
        div_sel_i = 3'b000;
        is_word_i = 1'b0;
        src1_i = '0;
        src2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 64'(div_done_o), 64'd0);
        chk("rst_res", div_res_o, 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        rst = 1'b0;

        run_op("divu_100_7", DIV_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        run_op("remu_100_7", DIV_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65);
        run_op("div_m100_7", DIV_DIV, 1'b0, -64'sd100, 64'd7,
               64'hFFFF_FFFF_FFFF_FFF2, 65);
        run_op("rem_m100_7", DIV_REM, 1'b0, -64'sd100, 64'd7,
               64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_op("rem_100_m7", DIV_REM, 1'b0, 64'd100, -64'sd7, 64'd2, 65);
        run_op("divu_by0", DIV_DIVU, 1'b0, 64'd12345, 64'd0,
               64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("rem_5_by0", DIV_REM, 1'b0, 64'd5, 64'd0, 64'd5, 1);
        run_op("div_ovf", DIV_DIV, 1'b0, 64'h8000_0000_0000_0000,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
        run_op("rem_ovf", DIV_REM, 1'b0, 64'h8000_0000_0000_0000,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        run_op("divw_1", DIV_DIV, 1'b1, 64'h0000_0001_8000_0000, 64'd1,
               64'hFFFF_FFFF_8000_0000, 33);
        run_op("divuw_2", DIV_DIVU, 1'b1, 64'h0000_0001_8000_0000, 64'd2,
               64'h0000_0000_4000_0000, 33);
        run_op("divw_ovf", DIV_DIV, 1'b1, 64'h0000_0000_8000_0000,
               64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("remw_m7_2", DIV_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("divuw_by0", DIV_DIVU, 1'b1, 64'h1234_5678_9ABC_DEF0,
               64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("remuw_by0", DIV_REMU, 1'b1, 64'h1234_5678_9ABC_DEF0,
               64'd0, 64'hFFFF_FFFF_9ABC_DEF0, 1);

        for (int i = 0; i < 3; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} >> $urandom_range(0, 48);
            if (rb == 64'd0) rb = 64'd1;
            run_op("divu_rand", DIV_DIVU, 1'b0, ra, rb, ra / rb, 65);
            run_op("remu_rand", DIV_REMU, 1'b0, ra, rb, ra % rb, 65);
        end

        // Flush ten cycles into a DIV, then a fresh DIVU the next cycle
        @(posedge clk); #1;
        drive(DIV_DIV, 1'b0, 64'd1000, 64'd3);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            chk("flush_pre_done", 64'(div_done_o), 64'd0);
        end
        flush_i = 1'b1;
        #1 chk("flush_stall", 64'(stall_o), 64'd0);
        chk("flush_done", 64'(div_done_o), 64'd0);
        run_op("flush_next", DIV_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 65);

        // Same again with a reset in place of the flush
        @(posedge clk); #1;
        drive(DIV_DIV, 1'b0, 64'd1000, 64'd3);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1 chk("rst_mid_done", 64'(div_done_o), 64'd0);
        run_op("rst_next", DIV_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 65);

        @(posedge clk); #1;
        chk("idle_res", div_res_o, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
